// File: rtl/yarvi_trace_buf.sv
// Retire-trace capture buffer: circular capture of retired instructions, freeze on trigger, oldest-first drain.
// Optional build macro YARVI_TRACE_TIMESTAMP_EN adds a free-running cycle stamp per entry and the rd_ts_o port.
module yarvi_trace_buf #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 16,
    parameter int POST  = 4,
    parameter int TS_W  = 16
) (
    input  logic                     clock_i,
    input  logic                     reset_n_i,
    input  logic                     valid_i,
    input  logic [1:0]               prv_i,
    input  logic [XLEN-1:0]          pc_i,
    input  logic [31:0]              insn_i,
    input  logic [4:0]               wb_rd_i,
    input  logic [XLEN-1:0]          wb_val_i,
    input  logic                     arm_i,
    input  logic                     disarm_i,
    input  logic                     trig_pc_en_i,
    input  logic [XLEN-1:0]          trig_pc_i,
    output logic [1:0]               state_o,
    output logic                     wrapped_o,
    output logic [$clog2(DEPTH):0]   rd_count_o,
    output logic                     rd_valid_o,
    input  logic                     rd_ready_i,
`ifdef YARVI_TRACE_TIMESTAMP_EN
    output logic [TS_W-1:0]          rd_ts_o,
`endif
    output logic [1:0]               rd_prv_o,
    output logic [XLEN-1:0]          rd_pc_o,
    output logic [31:0]              rd_insn_o,
    output logic [4:0]               rd_rd_o,
    output logic [XLEN-1:0]          rd_val_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [31:0] EBREAK = 32'h0010_0073;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ARMED  = 2'd1,
        ST_POST   = 2'd2,
        ST_FROZEN = 2'd3
    } state_e;

    typedef struct packed {
`ifdef YARVI_TRACE_TIMESTAMP_EN
        logic [TS_W-1:0] ts;
`endif
        logic [1:0]      prv;
        logic [XLEN-1:0] pc;
        logic [31:0]     insn;
        logic [4:0]      rd;
        logic [XLEN-1:0] val;
    } entry_t;

    state_e          state_q, state_d;
    logic [AW-1:0]   wrPtr_q, wrPtr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [CW-1:0]   postCnt_q, postCnt_d;
    logic            wrapped_q, wrapped_d;
    logic            writeEn;
    logic            trigger;
    logic            rdValid;
    logic [AW-1:0]   rdIdx;
    entry_t          wrEntry;
    entry_t          rdEntry;
    entry_t          mem_q [DEPTH];

    assign trigger = valid_i & ((trig_pc_en_i & (pc_i == trig_pc_i)) | (insn_i == EBREAK));

`ifdef YARVI_TRACE_TIMESTAMP_EN
    logic [TS_W-1:0] tsCnt_q;

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) tsCnt_q <= '0;
        else            tsCnt_q <= tsCnt_q + 1'b1;
    end

    assign wrEntry.ts = tsCnt_q;
`endif

    assign wrEntry.prv  = prv_i;
    assign wrEntry.pc   = pc_i;
    assign wrEntry.insn = insn_i;
    assign wrEntry.rd   = wb_rd_i;
    assign wrEntry.val  = wb_val_i;

    // Shared capture step for ARMED and POST: advance the pointer, saturate the count, flag overwrites.
    always_comb begin
        state_d   = state_q;
        wrPtr_d   = wrPtr_q;
        count_d   = count_q;
        postCnt_d = postCnt_q;
        wrapped_d = wrapped_q;
        writeEn   = 1'b0;
        rdValid   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (arm_i) begin
                    wrPtr_d   = '0;
                    count_d   = '0;
                    wrapped_d = 1'b0;
                    state_d   = ST_ARMED;
                end
            end
            ST_ARMED, ST_POST: begin
                if (valid_i) begin
                    writeEn = 1'b1;
                    wrPtr_d = wrPtr_q + 1'b1;
                    if (count_q == CW'(DEPTH)) wrapped_d = 1'b1;
                    else                        count_d   = count_q + 1'b1;
                end
                if (state_q == ST_ARMED) begin
                    if (trigger) begin
                        postCnt_d = CW'(POST);
                        state_d   = (POST > 0) ? ST_POST : ST_FROZEN;
                    end
                end else if (valid_i) begin
                    postCnt_d = postCnt_q - 1'b1;
                    if (postCnt_q == CW'(1)) state_d = ST_FROZEN;
                end
                // A manual freeze overrides whatever the trigger logic chose.
                if (disarm_i) state_d = ST_FROZEN;
            end
            ST_FROZEN: begin
                rdValid = (count_q != '0);
                if (count_q == '0)   state_d = ST_IDLE;
                else if (rd_ready_i) count_d = count_q - 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q   <= ST_IDLE;
            wrPtr_q   <= '0;
            count_q   <= '0;
            postCnt_q <= '0;
            wrapped_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wrPtr_q   <= wrPtr_d;
            count_q   <= count_d;
            postCnt_q <= postCnt_d;
            wrapped_q <= wrapped_d;
        end
    end

    // Storage is deliberately unreset; stale contents are masked by rd_valid.
    always_ff @(posedge clock_i) begin
        if (writeEn) mem_q[wrPtr_q] <= wrEntry;
    end

    assign rdIdx   = wrPtr_q - count_q[AW-1:0];
    assign rdEntry = rdValid ? mem_q[rdIdx] : '0;

    assign state_o    = state_q;
    assign wrapped_o  = wrapped_q;
    assign rd_count_o = count_q;
    assign rd_valid_o = rdValid;
`ifdef YARVI_TRACE_TIMESTAMP_EN
    assign rd_ts_o    = rdEntry.ts;
`endif
    assign rd_prv_o   = rdEntry.prv;
    assign rd_pc_o    = rdEntry.pc;
    assign rd_insn_o  = rdEntry.insn;
    assign rd_rd_o    = rdEntry.rd;
    assign rd_val_o   = rdEntry.val;

endmodule

// File: tb/tb_yarvi_trace_buf.sv
// Directed bench for yarvi_trace_buf: one DUT with POST=4, a second with POST=0 for the EBREAK freeze.
// Build with YARVI_TRACE_TIMESTAMP_EN to also exercise the timestamp field.
module tb_yarvi_trace_buf;

    localparam int XLEN  = 32;
    localparam int DEPTH = 16;
    localparam int TS_W  = 16;
    localparam logic [31:0] NOP    = 32'h0000_0013;
    localparam logic [31:0] EBREAK = 32'h0010_0073;

    logic            clock;
    logic            resetN;
    logic            valid;
    logic [1:0]      prv;
    logic [XLEN-1:0] pc;
    logic [31:0]     insn;
    logic [4:0]      wbRd;
    logic [XLEN-1:0] wbVal;
    logic            arm;
    logic            disarm;
    logic            trigPcEn;
    logic [XLEN-1:0] trigPc;
    logic            rdReady;

    logic [1:0]      state,   state0;
    logic            wrapped, wrapped0;
    logic [4:0]      rdCount, rdCount0;
    logic            rdValid, rdValid0;
    logic [1:0]      rdPrv,   rdPrv0;
    logic [XLEN-1:0] rdPc,    rdPc0;
    logic [31:0]     rdInsn,  rdInsn0;
    logic [4:0]      rdRd,    rdRd0;
    logic [XLEN-1:0] rdVal,   rdVal0;
`ifdef YARVI_TRACE_TIMESTAMP_EN
    logic [TS_W-1:0] rdTs,    rdTs0;
`endif

    int checks = 0;
    int errors = 0;

    yarvi_trace_buf #(.XLEN(XLEN), .DEPTH(DEPTH), .POST(4), .TS_W(TS_W)) dut (
        .clock_i(clock), .reset_n_i(resetN), .valid_i(valid), .prv_i(prv), .pc_i(pc),
        .insn_i(insn), .wb_rd_i(wbRd), .wb_val_i(wbVal), .arm_i(arm), .disarm_i(disarm),
        .trig_pc_en_i(trigPcEn), .trig_pc_i(trigPc), .state_o(state), .wrapped_o(wrapped),
        .rd_count_o(rdCount), .rd_valid_o(rdValid), .rd_ready_i(rdReady),
`ifdef YARVI_TRACE_TIMESTAMP_EN
        .rd_ts_o(rdTs),
`endif
        .rd_prv_o(rdPrv), .rd_pc_o(rdPc), .rd_insn_o(rdInsn), .rd_rd_o(rdRd), .rd_val_o(rdVal)
    );

    yarvi_trace_buf #(.XLEN(XLEN), .DEPTH(DEPTH), .POST(0), .TS_W(TS_W)) dut0 (
        .clock_i(clock), .reset_n_i(resetN), .valid_i(valid), .prv_i(prv), .pc_i(pc),
        .insn_i(insn), .wb_rd_i(wbRd), .wb_val_i(wbVal), .arm_i(arm), .disarm_i(disarm),
        .trig_pc_en_i(trigPcEn), .trig_pc_i(trigPc), .state_o(state0), .wrapped_o(wrapped0),
        .rd_count_o(rdCount0), .rd_valid_o(rdValid0), .rd_ready_i(rdReady),
`ifdef YARVI_TRACE_TIMESTAMP_EN
        .rd_ts_o(rdTs0),
`endif
        .rd_prv_o(rdPrv0), .rd_pc_o(rdPc0), .rd_insn_o(rdInsn0), .rd_rd_o(rdRd0), .rd_val_o(rdVal0)
    );

    // Free-running clock; stimulus changes 1 time unit after each rising edge.
    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic doReset();
        resetN   = 1'b0;
        valid    = 1'b0;
        prv      = '0;
        pc       = '0;
        insn     = '0;
        wbRd     = '0;
        wbVal    = '0;
        arm      = 1'b0;
        disarm   = 1'b0;
        trigPcEn = 1'b0;
        trigPc   = '0;
        rdReady  = 1'b0;
        tick();
        tick();
        resetN = 1'b1;
        tick();
    endtask

    task automatic pulseArm();
        arm = 1'b1;
        tick();
        arm = 1'b0;
    endtask

    task automatic pulseDisarm();
        disarm = 1'b1;
        tick();
        disarm = 1'b0;
    endtask

    // One retire beat; the writeback fields are derived from pc so drained entries can be re-predicted.
    task automatic applyStimulus(input logic [XLEN-1:0] pcVal, input logic [31:0] insnVal);
        valid = 1'b1;
        pc    = pcVal;
        insn  = insnVal;
        prv   = pcVal[3:2];
        wbRd  = pcVal[6:2];
        wbVal = pcVal ^ 32'hA5A5_0000;
        tick();
        valid = 1'b0;
    endtask

    task automatic test_reset();
        resetN = 1'b0;
        #1;
        checks++;
        if (state !== 2'd0 || rdValid !== 1'b0 || rdCount !== 5'd0 || wrapped !== 1'b0 || rdPc !== '0) begin
            errors++;
            $display("[TB] FAIL reset: state=%0d valid=%b count=%0d wrapped=%b pc=%h, expected 0 0 0 0 0",
                     state, rdValid, rdCount, wrapped, rdPc);
        end
        doReset();
    endtask

    task automatic test_basic();
        doReset();
        pulseArm();
        checks++;
        if (state !== 2'd1) begin
            errors++;
            $display("[TB] FAIL basic_armed: state=%0d expected 1", state);
        end
        applyStimulus(32'h100, NOP);
        applyStimulus(32'h104, NOP);
        applyStimulus(32'h108, NOP);
        pulseDisarm();
        checks++;
        if (state !== 2'd3 || rdCount !== 5'd3 || rdValid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL basic_frozen: state=%0d count=%0d valid=%b expected 3 3 1", state, rdCount, rdValid);
        end
        checks++;
        if (rdVal !== 32'hA5A5_0100 || rdRd !== 5'd0 || rdInsn !== NOP) begin
            errors++;
            $display("[TB] FAIL basic_fields: val=%h rd=%0d insn=%h expected a5a50100 0 %h", rdVal, rdRd, rdInsn, NOP);
        end
        rdReady = 1'b1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (rdPc !== 32'h100 + 32'(4 * i)) begin
                errors++;
                $display("[TB] FAIL basic_drain%0d: pc=%h expected %h", i, rdPc, 32'h100 + 32'(4 * i));
            end
            if (i == 1) begin
                checks++;
                if (rdPrv !== 2'd1 || rdRd !== 5'd1) begin
                    errors++;
                    $display("[TB] FAIL basic_prv: prv=%0d rd=%0d expected 1 1", rdPrv, rdRd);
                end
            end
            tick();
        end
        checks++;
        if (rdValid !== 1'b0 || rdCount !== 5'd0 || state !== 2'd3) begin
            errors++;
            $display("[TB] FAIL basic_empty: valid=%b count=%0d state=%0d expected 0 0 3", rdValid, rdCount, state);
        end
        tick();
        rdReady = 1'b0;
        checks++;
        if (state !== 2'd0) begin
            errors++;
            $display("[TB] FAIL basic_idle: state=%0d expected 0", state);
        end
    endtask

    task automatic test_wrap();
        doReset();
        pulseArm();
        trigPcEn = 1'b1;
        trigPc   = 32'h30;
        for (int i = 0; i < 30; i++) applyStimulus(32'(i * 4), NOP);
        trigPcEn = 1'b0;
        checks++;
        if (state !== 2'd3 || rdCount !== 5'd16 || wrapped !== 1'b1) begin
            errors++;
            $display("[TB] FAIL wrap_frozen: state=%0d count=%0d wrapped=%b expected 3 16 1", state, rdCount, wrapped);
        end
        rdReady = 1'b1;
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (rdValid !== 1'b1 || rdPc !== 32'(4 + 4 * i)) begin
                errors++;
                $display("[TB] FAIL wrap_drain%0d: valid=%b pc=%h expected 1 %h", i, rdValid, rdPc, 32'(4 + 4 * i));
            end
            tick();
        end
        tick();
        rdReady = 1'b0;
        checks++;
        if (state !== 2'd0 || wrapped !== 1'b1) begin
            errors++;
            $display("[TB] FAIL wrap_idle: state=%0d wrapped=%b expected 0 1", state, wrapped);
        end
        pulseArm();
        checks++;
        if (wrapped !== 1'b0 || rdCount !== 5'd0) begin
            errors++;
            $display("[TB] FAIL wrap_rearm: wrapped=%b count=%0d expected 0 0", wrapped, rdCount);
        end
    endtask

    task automatic test_ebreak();
        doReset();
        pulseArm();
        applyStimulus(32'h200, NOP);
        applyStimulus(32'h204, EBREAK);
        checks++;
        if (state0 !== 2'd3) begin
            errors++;
            $display("[TB] FAIL ebreak_frozen: state=%0d expected 3", state0);
        end
        applyStimulus(32'h208, NOP);
        checks++;
        if (rdCount0 !== 5'd2 || rdPc0 !== 32'h200) begin
            errors++;
            $display("[TB] FAIL ebreak_count: count=%0d pc=%h expected 2 200", rdCount0, rdPc0);
        end
        rdReady = 1'b1;
        tick();
        checks++;
        if (rdPc0 !== 32'h204 || rdInsn0 !== EBREAK) begin
            errors++;
            $display("[TB] FAIL ebreak_last: pc=%h insn=%h expected 204 %h", rdPc0, rdInsn0, EBREAK);
        end
        tick();
        rdReady = 1'b0;
        checks++;
        if (rdValid0 !== 1'b0) begin
            errors++;
            $display("[TB] FAIL ebreak_empty: valid=%b expected 0", rdValid0);
        end
    endtask

    task automatic test_ready_toggle();
        logic [XLEN-1:0] expPc [4];
        logic [4:0]      expCnt [4];
        expPc  = '{32'h304, 32'h304, 32'h308, 32'h308};
        expCnt = '{5'd2, 5'd2, 5'd1, 5'd1};
        doReset();
        pulseArm();
        applyStimulus(32'h300, NOP);
        applyStimulus(32'h304, NOP);
        applyStimulus(32'h308, NOP);
        pulseDisarm();
        for (int i = 0; i < 4; i++) begin
            rdReady = (i % 2 == 0);
            tick();
            checks++;
            if (rdPc !== expPc[i] || rdCount !== expCnt[i]) begin
                errors++;
                $display("[TB] FAIL toggle%0d: pc=%h count=%0d expected %h %0d", i, rdPc, rdCount, expPc[i], expCnt[i]);
            end
        end
        rdReady = 1'b0;
    endtask

    task automatic test_empty_freeze();
        doReset();
        pulseArm();
        pulseDisarm();
        checks++;
        if (state !== 2'd3 || rdValid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL empty_frozen: state=%0d valid=%b expected 3 0", state, rdValid);
        end
        tick();
        checks++;
        if (state !== 2'd0) begin
            errors++;
            $display("[TB] FAIL empty_idle: state=%0d expected 0", state);
        end
        pulseArm();
        trigPcEn = 1'b1;
        trigPc   = 32'h500;
        disarm   = 1'b1;
        applyStimulus(32'h500, NOP);
        disarm   = 1'b0;
        trigPcEn = 1'b0;
        checks++;
        if (state !== 2'd3 || rdCount !== 5'd1 || rdPc !== 32'h500) begin
            errors++;
            $display("[TB] FAIL disarm_trigger: state=%0d count=%0d pc=%h expected 3 1 500", state, rdCount, rdPc);
        end
    endtask

    task automatic test_reset_mid_drain();
        doReset();
        pulseArm();
        for (int i = 0; i < 8; i++) applyStimulus(32'h600 + 32'(4 * i), NOP);
        pulseDisarm();
        rdReady = 1'b1;
        tick();
        tick();
        tick();
        rdReady = 1'b0;
        checks++;
        if (rdCount !== 5'd5 || rdPc !== 32'h60C) begin
            errors++;
            $display("[TB] FAIL middrain_count: count=%0d pc=%h expected 5 60c", rdCount, rdPc);
        end
        resetN = 1'b0;
        #1;
        checks++;
        if (state !== 2'd0 || rdValid !== 1'b0 || rdCount !== 5'd0 || rdPc !== '0) begin
            errors++;
            $display("[TB] FAIL middrain_reset: state=%0d valid=%b count=%0d pc=%h expected 0 0 0 0",
                     state, rdValid, rdCount, rdPc);
        end
        doReset();
    endtask

`ifdef YARVI_TRACE_TIMESTAMP_EN
    task automatic test_timestamp();
        logic [TS_W-1:0] firstTs;
        doReset();
        pulseArm();
        applyStimulus(32'h700, NOP);
        tick();
        tick();
        applyStimulus(32'h704, NOP);
        pulseDisarm();
        firstTs = rdTs;
        rdReady = 1'b1;
        tick();
        rdReady = 1'b0;
        checks++;
        if (rdTs - firstTs !== TS_W'(3)) begin
            errors++;
            $display("[TB] FAIL timestamp_delta: delta=%0d expected 3", rdTs - firstTs);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_ebreak();
        test_ready_toggle();
        test_empty_freeze();
        test_reset_mid_drain();
`ifdef YARVI_TRACE_TIMESTAMP_EN
        test_timestamp();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
